hyper_trap_ctrl: RTL and testbench
==================================

HYPER_TRAP_CTRL -- requirements
Module: hyper_trap_ctrl

Interface
REQ-001 SHALL have parameter TRAP_BITS, default 6, giving the trap port index width (1..6).
REQ-002 SHALL have parameter VECTOR_BASE, default 16'h8000, giving the entry vector for trap port 0.
REQ-003 SHALL have parameter MAP_REGS, default 4, giving the number of mapper registers saved and restored (1..6).
REQ-004 SHALL have one clock and a synchronous active-high reset.
REQ-005 Port: clk  in  1  clock.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: hyper_cs  in  1  hypervisor register select.
REQ-008 Port: hyper_addr  in  8  hypervisor register offset.
REQ-009 Port: cpu_addr  in  16  CPU address bus.
REQ-010 Port: cpu_write, cpu_sync, ready  in  1 each  CPU write, opcode fetch, bus ready.
REQ-011 Port: cpu_ext_data_i  in  8  memory read data.
REQ-012 Port: cpu_data_o  in  8  CPU write data.
REQ-013 Port: cpu_data_i  out  8  data presented to the CPU.
REQ-014 Port: hyper_mode, map_enable, busy  out  1 each  in hypervisor, mapper enable, sequence active.
REQ-015 Port: mapper_reg_sel  out  3  mapper register index.
REQ-016 Port: mapper_reg  in  8  mapper read data.
REQ-017 Port: mapper_wr  out  1  mapper restore strobe.
REQ-018 Port: mapper_wdata  out  8  mapper restore data.
REQ-019 Port: saved_pc  out  16  captured return PC.
REQ-020 Port: saved_p  out  8  captured flags.

Function
REQ-021 Trap request SHALL be hyper_cs & ready & cpu_write & hyper_addr[7:6]==2'b01; it SHALL be an entry when hyper_mode=0 and an exit when hyper_mode=1.
REQ-022 Requests SHALL be ignored outside IDLE.
REQ-023 On entry request: port = hyper_addr[TRAP_BITS-1:0] latched; vector = VECTOR_BASE + port*4; hyper_mode=1 and map gate=0 from the next cycle.
REQ-024 Entry states SHALL be EN_PHP_FETCH -> EN_PHP_DEC -> EN_PHP_EX -> EN_JMP_FETCH -> EN_PCL -> EN_PCH -> IDLE.
REQ-025 Each entry transition SHALL occur on ready; *_FETCH transitions SHALL also require cpu_sync.
REQ-026 Entry drive values: EN_PHP_* drive 8'h08; EN_JMP_FETCH drives 8'h4C; EN_PCL drives vector[7:0]; EN_PCH drives vector[15:8].
REQ-027 On the EN_PHP_FETCH transition, saved_pc SHALL capture cpu_addr.
REQ-028 On the EN_PHP_EX transition, saved_p SHALL capture cpu_data_o.
REQ-029 Mapper save during entry: on each ready-qualified entry transition k (k=0..MAP_REGS-1), mapper_reg_sel=k and shadow[k] captures mapper_reg.
REQ-030 Exit states SHALL be EX_CLE_SEE_FETCH -> EX_CLE_SEE_EX -> EX_PLP_FETCH -> EX_PLP_DEC -> EX_PLP_EX -> EX_JMP_FETCH -> EX_PCL -> EX_PCH -> IDLE, with the same ready/cpu_sync rules as entry.
REQ-031 Exit drive values: EX_CLE_SEE_* drive {7'b0000001, saved_p[5]}; EX_PLP_FETCH/DEC drive 8'h28; EX_PLP_EX drives saved_p; EX_JMP_FETCH drives 8'h4C; EX_PCL/EX_PCH drive saved_pc low/high.
REQ-032 Mapper restore during exit: on ready-qualified exit transition k (k=0..MAP_REGS-1), mapper_wr=1, mapper_reg_sel=k, mapper_wdata=shadow[k]; mapper_wr=0 otherwise.
REQ-033 On the EX_PCH -> IDLE transition, hyper_mode=0 and map gate=1 from the next cycle.
REQ-034 cpu_data_i SHALL equal cpu_ext_data_i in IDLE with no request, and the state drive value otherwise (combinational).
REQ-035 map_enable SHALL equal map gate only in IDLE with no request, and 0 otherwise.
REQ-036 busy=1 in any non-IDLE state.
REQ-037 ready=0 SHALL hold the state, all captures and the save/restore index; no mapper_wr.
REQ-038 An unused state encoding SHALL return to IDLE.

Reset
REQ-039 Reset SHALL force IDLE, hyper_mode=0, map gate=1, mapper_wr=0, saved_pc=0, saved_p=0, shadows=0, index=0, cpu_data_i=cpu_ext_data_i.
REQ-040 Reset mid-sequence SHALL abort the sequence with no further mapper_wr.

Verification
REQ-041 Write to hyper_addr 8'h45 with sync at cpu_addr 16'h1234 and cpu_data_o 8'h24 at PHP_EX -> CPU sees 08,08,08,4C,14,80; saved_pc=16'h1234, saved_p=8'h24; hyper_mode=1.
REQ-042 Exit with saved_p=8'h24 -> CPU sees 03,03,28,28,24,4C,34,12; hyper_mode=0; map_enable=1 in IDLE.
REQ-043 MAP_REGS=4, mapper values AA,BB,CC,DD captured at entry -> exit issues 4 mapper_wr strobes with sel 0..3 and data AA..DD.
REQ-044 ready low for 3 cycles inside EN_PCL -> state and cpu_data_i held, no capture; sequence completes normally afterwards.
REQ-045 Reset asserted in EX_PLP_DEC -> IDLE next cycle, hyper_mode=0, mapper_wr=0; a second hyper_cs write during a sequence is ignored.

Source files
------------

// File: rtl/hyper_trap_ctrl.sv
// hyper_trap_ctrl: hypervisor trap entry/exit sequencer that feeds synthetic opcodes to the CPU and saves/restores mapper state
module hyper_trap_ctrl #(
  parameter int          TRAP_BITS   = 6,
  parameter logic [15:0] VECTOR_BASE = 16'h8000,
  parameter int          MAP_REGS    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hyper_cs,
  input  logic [7:0]  hyper_addr,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic        cpu_sync,
  input  logic        ready,
  input  logic [7:0]  cpu_ext_data_i,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        hyper_mode,
  output logic        map_enable,
  output logic        busy,
  output logic [2:0]  mapper_reg_sel,
  input  logic [7:0]  mapper_reg,
  output logic        mapper_wr,
  output logic [7:0]  mapper_wdata,
  output logic [15:0] saved_pc,
  output logic [7:0]  saved_p
);
  typedef enum logic [3:0] {
    IDLE             = 4'd0,
    EN_PHP_FETCH     = 4'd1,
    EN_PHP_DEC       = 4'd2,
    EN_PHP_EX        = 4'd3,
    EN_JMP_FETCH     = 4'd4,
    EN_PCL           = 4'd5,
    EN_PCH           = 4'd6,
    EX_CLE_SEE_FETCH = 4'd7,
    EX_CLE_SEE_EX    = 4'd8,
    EX_PLP_FETCH     = 4'd9,
    EX_PLP_DEC       = 4'd10,
    EX_PLP_EX        = 4'd11,
    EX_JMP_FETCH     = 4'd12,
    EX_PCL           = 4'd13,
    EX_PCH           = 4'd14
  } state_t;
  state_t               state, state_nx;
  logic [TRAP_BITS-1:0] port;
  logic [15:0]          vector;
  logic [2:0]           idx;
  logic [7:0]           shadow [MAP_REGS];
  logic [7:0]           shadow_rd;
  logic [7:0]           drive;
  logic                 gate, req, idle, fetch, adv, slot, in_entry, in_exit;
  assign req      = hyper_cs & ready & cpu_write & (hyper_addr[7:6] == 2'b01);
  assign idle     = state == IDLE;
  assign fetch    = state inside {EN_PHP_FETCH, EN_JMP_FETCH, EX_CLE_SEE_FETCH, EX_PLP_FETCH, EX_JMP_FETCH};
  assign adv      = !idle && ready && (!fetch || cpu_sync);
  assign slot     = int'(idx) < MAP_REGS;
  assign in_entry = state inside {[EN_PHP_FETCH:EN_PCH]};
  assign in_exit  = state inside {[EX_CLE_SEE_FETCH:EX_PCH]};
  assign vector   = VECTOR_BASE + 16'({port, 2'b00});
  // Opcode stream: PHP then JMP vector on entry; CLE/SEE, PLP, JMP saved_pc on exit
  always_comb begin
    state_nx = state;
    drive    = 8'h00;
    case (state)
      IDLE:             state_nx = req ? (hyper_mode ? EX_CLE_SEE_FETCH : EN_PHP_FETCH) : IDLE;
      EN_PHP_FETCH:     begin drive = 8'h08; state_nx = adv ? EN_PHP_DEC : state; end
      EN_PHP_DEC:       begin drive = 8'h08; state_nx = adv ? EN_PHP_EX : state; end
      EN_PHP_EX:        begin drive = 8'h08; state_nx = adv ? EN_JMP_FETCH : state; end
      EN_JMP_FETCH:     begin drive = 8'h4C; state_nx = adv ? EN_PCL : state; end
      EN_PCL:           begin drive = vector[7:0]; state_nx = adv ? EN_PCH : state; end
      EN_PCH:           begin drive = vector[15:8]; state_nx = adv ? IDLE : state; end
      EX_CLE_SEE_FETCH: begin drive = {7'b0000001, saved_p[5]}; state_nx = adv ? EX_CLE_SEE_EX : state; end
      EX_CLE_SEE_EX:    begin drive = {7'b0000001, saved_p[5]}; state_nx = adv ? EX_PLP_FETCH : state; end
      EX_PLP_FETCH:     begin drive = 8'h28; state_nx = adv ? EX_PLP_DEC : state; end
      EX_PLP_DEC:       begin drive = 8'h28; state_nx = adv ? EX_PLP_EX : state; end
      EX_PLP_EX:        begin drive = saved_p; state_nx = adv ? EX_JMP_FETCH : state; end
      EX_JMP_FETCH:     begin drive = 8'h4C; state_nx = adv ? EX_PCL : state; end
      EX_PCL:           begin drive = saved_pc[7:0]; state_nx = adv ? EX_PCH : state; end
      EX_PCH:           begin drive = saved_pc[15:8]; state_nx = adv ? IDLE : state; end
      default:          state_nx = IDLE;
    endcase
  end
  always_comb begin
    shadow_rd = 8'h00;
    for (int i = 0; i < MAP_REGS; i++)
      shadow_rd = (idx == 3'(i)) ? shadow[i] : shadow_rd;
  end
  assign cpu_data_i     = (idle && !req) ? cpu_ext_data_i : drive;
  assign map_enable     = gate & idle & !req;
  assign busy           = !idle;
  assign mapper_reg_sel = idx;
  assign mapper_wr      = in_exit & adv & slot;
  assign mapper_wdata   = mapper_wr ? shadow_rd : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hyper_mode <= 1'b0;
      gate       <= 1'b1;
      saved_pc   <= 16'h0000;
      saved_p    <= 8'h00;
      idx        <= 3'd0;
      port       <= '0;
      for (int i = 0; i < MAP_REGS; i++) shadow[i] <= 8'h00;
    end else begin
      state <= state_nx;
      if (idle && req && !hyper_mode) begin
        port       <= hyper_addr[TRAP_BITS-1:0];
        hyper_mode <= 1'b1;
        gate       <= 1'b0;
      end
      if (state == EN_PHP_FETCH && adv) saved_pc <= cpu_addr;
      if (state == EN_PHP_EX && adv) saved_p <= cpu_data_o;
      if (adv) begin
        idx <= (state_nx == IDLE) ? 3'd0 : idx + 3'd1;
        for (int i = 0; i < MAP_REGS; i++)
          if (in_entry && slot && idx == 3'(i)) shadow[i] <= mapper_reg;
        if (state == EX_PCH) begin
          hyper_mode <= 1'b0;
          gate       <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hyper_trap_ctrl.sv
// tb_hyper_trap_ctrl: table-driven entry/exit vectors plus hand sequences for stalls, ignored writes and mid-sequence reset
module tb_hyper_trap_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        hyper_cs = 1'b0, cpu_write = 1'b0, cpu_sync = 1'b0, ready = 1'b0;
  logic [7:0]  hyper_addr = 8'h00, cpu_ext_data_i = 8'h5A, cpu_data_o = 8'h00, mapper_reg = 8'h00;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_i, mapper_wdata, saved_p;
  logic        hyper_mode, map_enable, busy, mapper_wr;
  logic [2:0]  mapper_reg_sel;
  logic [15:0] saved_pc;
  int          checks = 0, failures = 0;

  hyper_trap_ctrl dut (
    .clk(clk), .reset(reset), .hyper_cs(hyper_cs), .hyper_addr(hyper_addr),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_sync(cpu_sync), .ready(ready),
    .cpu_ext_data_i(cpu_ext_data_i), .cpu_data_o(cpu_data_o), .cpu_data_i(cpu_data_i),
    .hyper_mode(hyper_mode), .map_enable(map_enable), .busy(busy),
    .mapper_reg_sel(mapper_reg_sel), .mapper_reg(mapper_reg), .mapper_wr(mapper_wr),
    .mapper_wdata(mapper_wdata), .saved_pc(saved_pc), .saved_p(saved_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cs; logic [7:0] ha; logic wr; logic rdy; logic sync;
    logic [15:0] ca; logic [7:0] dout; logic [7:0] mreg; logic [7:0] ext;
    logic cdi; logic csel;
    logic [7:0] e_di; logic e_busy; logic e_hyp; logic e_men; logic e_mwr;
    logic [2:0] e_sel; logic [7:0] e_wd; logic [15:0] e_spc; logic [7:0] e_sp;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drv(input logic cs_v, input logic [7:0] ha_v, input logic rdy_v, input logic sync_v);
    hyper_cs = cs_v; cpu_write = cs_v; hyper_addr = ha_v; ready = rdy_v; cpu_sync = sync_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h5A,1'b0,1'b0,1'b1,1'b0,3'd0,8'h00,16'h0000,8'h00};
    tbl[1]  = '{1'b1,8'h45,1'b1,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,3'd0,8'h00,16'h0000,8'h00};
    tbl[2]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h9999,8'h00,8'h11,8'h5A,1'b1,1'b1,8'h08,1'b1,1'b1,1'b0,1'b0,3'd0,8'h00,16'h0000,8'h00};
    tbl[3]  = '{1'b0,8'h00,1'b0,1'b1,1'b1,16'h1234,8'h00,8'hAA,8'h5A,1'b1,1'b1,8'h08,1'b1,1'b1,1'b0,1'b0,3'd0,8'h00,16'h0000,8'h00};
    tbl[4]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'hBB,8'h5A,1'b1,1'b1,8'h08,1'b1,1'b1,1'b0,1'b0,3'd1,8'h00,16'h1234,8'h00};
    tbl[5]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h24,8'hCC,8'h5A,1'b1,1'b1,8'h08,1'b1,1'b1,1'b0,1'b0,3'd2,8'h00,16'h1234,8'h00};
    tbl[6]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h77,8'h5A,1'b1,1'b1,8'h4C,1'b1,1'b1,1'b0,1'b0,3'd3,8'h00,16'h1234,8'h24};
    tbl[7]  = '{1'b0,8'h00,1'b0,1'b1,1'b1,16'h0000,8'h00,8'hDD,8'h5A,1'b1,1'b1,8'h4C,1'b1,1'b1,1'b0,1'b0,3'd3,8'h00,16'h1234,8'h24};
    tbl[8]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'hEE,8'h5A,1'b1,1'b0,8'h14,1'b1,1'b1,1'b0,1'b0,3'd4,8'h00,16'h1234,8'h24};
    tbl[9]  = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h80,1'b1,1'b1,1'b0,1'b0,3'd5,8'h00,16'h1234,8'h24};
    tbl[10] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h5A,1'b0,1'b1,1'b0,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tbl[11] = '{1'b1,8'h40,1'b1,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tbl[12] = '{1'b0,8'h00,1'b0,1'b1,1'b1,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b1,8'h03,1'b1,1'b1,1'b0,1'b1,3'd0,8'hAA,16'h1234,8'h24};
    tbl[13] = '{1'b0,8'h00,1'b0,1'b0,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b1,8'h03,1'b1,1'b1,1'b0,1'b0,3'd1,8'h00,16'h1234,8'h24};
    tbl[14] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b1,8'h03,1'b1,1'b1,1'b0,1'b1,3'd1,8'hBB,16'h1234,8'h24};
    tbl[15] = '{1'b0,8'h00,1'b0,1'b1,1'b1,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b1,8'h28,1'b1,1'b1,1'b0,1'b1,3'd2,8'hCC,16'h1234,8'h24};
    tbl[16] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b1,8'h28,1'b1,1'b1,1'b0,1'b1,3'd3,8'hDD,16'h1234,8'h24};
    tbl[17] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h24,1'b1,1'b1,1'b0,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tbl[18] = '{1'b0,8'h00,1'b0,1'b1,1'b1,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h4C,1'b1,1'b1,1'b0,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tbl[19] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h34,1'b1,1'b1,1'b0,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tbl[20] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h12,1'b1,1'b1,1'b0,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tbl[21] = '{1'b0,8'h00,1'b0,1'b1,1'b0,16'h0000,8'h00,8'h00,8'h5A,1'b1,1'b0,8'h5A,1'b0,1'b0,1'b1,1'b0,3'd0,8'h00,16'h1234,8'h24};
    tick();
    tick();
    reset = 1'b0;
    for (int r = 0; r < 22; r++) begin
      hyper_cs = tbl[r].cs; hyper_addr = tbl[r].ha; cpu_write = tbl[r].wr; ready = tbl[r].rdy;
      cpu_sync = tbl[r].sync; cpu_addr = tbl[r].ca; cpu_data_o = tbl[r].dout;
      mapper_reg = tbl[r].mreg; cpu_ext_data_i = tbl[r].ext;
      @(negedge clk);
      if (tbl[r].cdi) chk("cpu_data_i", r, {8'h00, cpu_data_i}, {8'h00, tbl[r].e_di});
      chk("busy", r, {15'd0, busy}, {15'd0, tbl[r].e_busy});
      chk("hyper_mode", r, {15'd0, hyper_mode}, {15'd0, tbl[r].e_hyp});
      chk("map_enable", r, {15'd0, map_enable}, {15'd0, tbl[r].e_men});
      chk("mapper_wr", r, {15'd0, mapper_wr}, {15'd0, tbl[r].e_mwr});
      if (tbl[r].csel) chk("mapper_reg_sel", r, {13'd0, mapper_reg_sel}, {13'd0, tbl[r].e_sel});
      if (tbl[r].e_mwr) chk("mapper_wdata", r, {8'h00, mapper_wdata}, {8'h00, tbl[r].e_wd});
      chk("saved_pc", r, saved_pc, tbl[r].e_spc);
      chk("saved_p", r, {8'h00, saved_p}, {8'h00, tbl[r].e_sp});
      tick();
    end
    // Second trap through port 1 (vector 8004), with a stray write and a ready stall
    cpu_addr = 16'hBEEF; cpu_data_o = 8'h81; cpu_ext_data_i = 8'h5A;
    drv(1'b1, 8'h41, 1'b1, 1'b0); tick();
    drv(1'b0, 8'h00, 1'b1, 1'b1); @(negedge clk); chk("h_php_fetch", 100, {8'h00, cpu_data_i}, 16'h0008); tick();
    drv(1'b1, 8'h45, 1'b1, 1'b0); @(negedge clk); chk("h_php_dec", 101, {8'h00, cpu_data_i}, 16'h0008); tick();
    drv(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk); chk("h_php_ex_stray", 102, {8'h00, cpu_data_i}, 16'h0008); tick();
    drv(1'b0, 8'h00, 1'b1, 1'b1); @(negedge clk); chk("h_jmp", 103, {8'h00, cpu_data_i}, 16'h004C); tick();
    for (int s = 0; s < 3; s++) begin
      drv(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("h_stall_di", 104 + s, {8'h00, cpu_data_i}, 16'h0004);
      chk("h_stall_busy", 104 + s, {15'd0, busy}, 16'd1);
      tick();
    end
    drv(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk); chk("h_pcl", 107, {8'h00, cpu_data_i}, 16'h0004); tick();
    @(negedge clk); chk("h_pch", 108, {8'h00, cpu_data_i}, 16'h0080); tick();
    @(negedge clk);
    chk("h_idle_busy", 109, {15'd0, busy}, 16'd0);
    chk("h_idle_hyp", 109, {15'd0, hyper_mode}, 16'd1);
    chk("h_saved_pc", 109, saved_pc, 16'hBEEF);
    chk("h_saved_p", 109, {8'h00, saved_p}, 16'h0081);
    // Exit with saved_p[5]=0, then reset in EX_PLP_DEC
    drv(1'b1, 8'h40, 1'b1, 1'b0); tick();
    drv(1'b0, 8'h00, 1'b1, 1'b1); @(negedge clk);
    chk("h_cle_fetch", 110, {8'h00, cpu_data_i}, 16'h0002);
    chk("h_cle_wr", 110, {15'd0, mapper_wr}, 16'd1);
    tick();
    drv(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk); chk("h_cle_ex", 111, {8'h00, cpu_data_i}, 16'h0002); tick();
    drv(1'b0, 8'h00, 1'b1, 1'b1); @(negedge clk); chk("h_plp_fetch", 112, {8'h00, cpu_data_i}, 16'h0028); tick();
    drv(1'b0, 8'h00, 1'b1, 1'b0); @(negedge clk); chk("h_plp_dec", 113, {8'h00, cpu_data_i}, 16'h0028);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 114, {15'd0, busy}, 16'd0);
    chk("rst_hyp", 114, {15'd0, hyper_mode}, 16'd0);
    chk("rst_mwr", 114, {15'd0, mapper_wr}, 16'd0);
    chk("rst_men", 114, {15'd0, map_enable}, 16'd1);
    chk("rst_spc", 114, saved_pc, 16'h0000);
    chk("rst_sp", 114, {8'h00, saved_p}, 16'h0000);
    chk("rst_di", 114, {8'h00, cpu_data_i}, 16'h005A);
    tick();
    @(negedge clk);
    chk("post_rst_mwr", 115, {15'd0, mapper_wr}, 16'd0);
    chk("post_rst_busy", 115, {15'd0, busy}, 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
